// File: rtl/mux_dest_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_dest_arb_if : FIFO-head / merged-stream bundle for mux_dest_arb
// Rev 1.0
// ---------------------------------------------------------------------------
interface mux_dest_arb_if #(
  parameter int DATA_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] fifo0_data;
  logic                  fifo0_empty;
  logic                  fifo0_pop;
  logic [DATA_WIDTH-1:0] fifo1_data;
  logic                  fifo1_empty;
  logic                  fifo1_pop;
  logic                  stall_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  err_dest;

  modport master (
    output fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, stall_in,
    input  fifo0_pop, fifo1_pop, data_out, valid_out, err_dest
  );

  modport slave (
    input  fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, stall_in,
    output fifo0_pop, fifo1_pop, data_out, valid_out, err_dest
  );
endinterface
`default_nettype wire

// File: rtl/mux_dest_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_dest_arb : burst-limited round-robin merge of two FWFT destination FIFOs
// Optional macro DEST_CHECK_EN enables the sticky destination-bit check.
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_dest_arb #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int MAX_BURST  = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  mux_dest_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SERVE0 = 2'd1,
    S_SERVE1 = 2'd2
  } state_t;

  localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_burst_cnt;
  logic                  r_last_served;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;

  logic w_ne0;
  logic w_ne1;
  logic w_burst_left;
  logic w_grant0;
  logic w_grant1;

  assign w_ne0        = ~bus.fifo0_empty;
  assign w_ne1        = ~bus.fifo1_empty;
  assign w_burst_left = (r_burst_cnt < c_max_burst);

  // Grant depends only on registered arbitration state and the live flags.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset && !bus.stall_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_ne0 && (!w_ne1 || r_last_served)) w_grant0 = 1'b1;
          else if (w_ne1)                         w_grant1 = 1'b1;
        end
        S_SERVE0: begin
          if (w_ne0 && (!w_ne1 || w_burst_left)) w_grant0 = 1'b1;
          else if (w_ne1)                        w_grant1 = 1'b1;
        end
        S_SERVE1: begin
          if (w_ne1 && (!w_ne0 || w_burst_left)) w_grant1 = 1'b1;
          else if (w_ne0)                        w_grant0 = 1'b1;
        end
        default: begin
          w_grant0 = 1'b0;
          w_grant1 = 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo0_pop = w_grant0;
  assign bus.fifo1_pop = w_grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_burst_cnt   <= '0;
      r_last_served <= 1'b1;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
    end else if (bus.stall_in) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_grant0 | w_grant1;
      r_data_out  <= w_grant0 ? bus.fifo0_data :
                     w_grant1 ? bus.fifo1_data : '0;
      if (w_grant0) begin
        if (r_state == S_SERVE0)
          r_burst_cnt <= w_burst_left ? r_burst_cnt + c_one : r_burst_cnt;
        else
          r_burst_cnt <= c_one;
        if (r_state == S_SERVE1) r_last_served <= 1'b1;
        r_state <= S_SERVE0;
      end else if (w_grant1) begin
        if (r_state == S_SERVE1)
          r_burst_cnt <= w_burst_left ? r_burst_cnt + c_one : r_burst_cnt;
        else
          r_burst_cnt <= c_one;
        if (r_state == S_SERVE0) r_last_served <= 1'b0;
        r_state <= S_SERVE1;
      end else if (r_state != S_IDLE) begin
        r_last_served <= (r_state == S_SERVE1);
        r_burst_cnt   <= '0;
        r_state       <= S_IDLE;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid_out = r_valid_out;

`ifdef DEST_CHECK_EN
  logic r_err_dest;

  // Source index equals the expected value of the destination bit.
  always_ff @(posedge clk) begin
    if (reset)
      r_err_dest <= 1'b0;
    else if ((w_grant0 &&  bus.fifo0_data[DEST_BIT]) ||
             (w_grant1 && !bus.fifo1_data[DEST_BIT]))
      r_err_dest <= 1'b1;
  end

  assign bus.err_dest = r_err_dest;
`else
  assign bus.err_dest = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_dest_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_dest_arb : directed + random bench against a queue-based arbiter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mux_dest_arb;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_dest_arb_if #(.DATA_WIDTH(DW)) bus ();

  mux_dest_arb #(.DATA_WIDTH(DW), .DEST_BIT(DB), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] got[$];

  // Model state: who is being served (-1 none), run length, last served FIFO.
  int m_src  = -1;
  int m_run  = 0;
  int m_last = 1;
  bit m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(bit ne0, bit ne1, bit rst, bit stall);
    bit ne_own, ne_oth;
    if (rst || stall) return -1;
    if (m_src < 0) begin
      if (ne0 && ne1) return (m_last == 0) ? 1 : 0;
      if (ne0) return 0;
      if (ne1) return 1;
      return -1;
    end
    ne_own = (m_src == 0) ? ne0 : ne1;
    ne_oth = (m_src == 0) ? ne1 : ne0;
    if (ne_own && (!ne_oth || m_run < MB)) return m_src;
    if (ne_oth) return 1 - m_src;
    return -1;
  endfunction

  task automatic cycle(input bit rst_v, input bit stall_v);
    int            g;
    logic [DW-1:0] w;
    @(negedge clk);
    reset           = rst_v;
    bus.stall_in    = stall_v;
    bus.fifo0_empty = (q0.size() == 0);
    bus.fifo1_empty = (q1.size() == 0);
    bus.fifo0_data  = (q0.size() != 0) ? q0[0] : '0;
    bus.fifo1_data  = (q1.size() != 0) ? q1[0] : '0;
    #1;
    g = model_grant(q0.size() != 0, q1.size() != 0, rst_v, stall_v);
    check("pop0", {31'd0, bus.fifo0_pop}, {31'd0, g == 0});
    check("pop1", {31'd0, bus.fifo1_pop}, {31'd0, g == 1});
    @(posedge clk);
    #1;
    w = '0;
    if (g == 0) w = q0.pop_front();
    if (g == 1) w = q1.pop_front();
    if (rst_v) begin
      m_src = -1; m_run = 0; m_last = 1; m_err = 1'b0;
    end else if (!stall_v) begin
      if (g < 0) begin
        if (m_src >= 0) begin m_last = m_src; m_src = -1; m_run = 0; end
      end else if (g == m_src) begin
        m_run = (m_run < MB) ? m_run + 1 : MB;
      end else begin
        if (m_src >= 0) m_last = m_src;
        m_src = g; m_run = 1;
      end
`ifdef DEST_CHECK_EN
      if (g >= 0 && int'(w[DB]) != g) m_err = 1'b1;
`endif
    end
    check("data_out",  {26'd0, bus.data_out},  {26'd0, w});
    check("valid_out", {31'd0, bus.valid_out}, {31'd0, g >= 0});
    check("err_dest",  {31'd0, bus.err_dest},  {31'd0, m_err});
    if (bus.valid_out) got.push_back(bus.data_out);
  endtask

  task automatic check_seq(input string tag, input logic [DW-1:0] exp[5]);
    check({tag, "_len"}, got.size(), 5);
    for (int i = 0; i < 5; i++)
      check(tag, {26'd0, (i < got.size()) ? got[i] : 6'h3F}, {26'd0, exp[i]});
  endtask

  function automatic logic [DW-1:0] rand_word(int src);
    logic [DW-1:0] v;
    v     = DW'($urandom);
    v[DB] = ($urandom_range(0, 9) == 0) ? ~src[0] : src[0];
    return v;
  endfunction

  logic [DW-1:0] seq3[5];
  logic [DW-1:0] head0;

  initial begin
    reset           = 1'b1;
    bus.stall_in    = 1'b0;
    bus.fifo0_data  = '0;
    bus.fifo1_data  = '0;
    bus.fifo0_empty = 1'b1;
    bus.fifo1_empty = 1'b1;
    seq3 = '{6'b10_0001, 6'b10_0100, 6'b11_0010, 6'b11_0011, 6'b10_0101};

    // Reset with both FIFOs non-empty: nothing popped.
    q0.push_back(6'b10_0001); q1.push_back(6'b11_0010);
    cycle(1, 0); cycle(1, 0);
    q0.delete(); q1.delete();

    // Single FIFO, back-to-back words then idle.
    got.delete();
    q0.push_back(6'b10_0001); q0.push_back(6'b10_0100);
    repeat (3) cycle(0, 0);
    check("single_len", got.size(), 2);
    if (got.size() == 2) begin
      check("single_w0", {26'd0, got[0]}, {26'd0, 6'b10_0001});
      check("single_w1", {26'd0, got[1]}, {26'd0, 6'b10_0100});
    end

    // Burst-limited interleave.
    cycle(1, 0); got.delete();
    q0.push_back(seq3[0]); q0.push_back(seq3[1]); q0.push_back(seq3[4]);
    q1.push_back(seq3[2]); q1.push_back(seq3[3]);
    repeat (6) cycle(0, 0);
    check_seq("burst_seq", seq3);

    // Same sequence with a two-cycle stall in the middle.
    cycle(1, 0); got.delete();
    q0.push_back(seq3[0]); q0.push_back(seq3[1]); q0.push_back(seq3[4]);
    q1.push_back(seq3[2]); q1.push_back(seq3[3]);
    cycle(0, 0); cycle(0, 0);
    cycle(0, 1); cycle(0, 1);
    repeat (4) cycle(0, 0);
    check_seq("stall_seq", seq3);

    // Wrong destination bit on FIFO0 head.
    cycle(1, 0);
    q0.push_back(6'b11_0010);
    cycle(0, 0); cycle(0, 0);
`ifdef DEST_CHECK_EN
    check("err_sticky", {31'd0, bus.err_dest}, 32'd1);
`else
    check("err_tied", {31'd0, bus.err_dest}, 32'd0);
`endif
    cycle(1, 0);
    check("err_cleared", {31'd0, bus.err_dest}, 32'd0);

    // Reset mid SERVE1 burst: FIFO0 must win first afterwards.
    repeat (4) q1.push_back(rand_word(1));
    cycle(0, 0);
    head0 = 6'b10_0111;
    q0.push_back(head0); q0.push_back(6'b10_1000);
    cycle(1, 0); got.delete();
    cycle(0, 0);
    check("rst_first", {26'd0, (got.size() != 0) ? got[0] : 6'h3F}, {26'd0, head0});
    repeat (8) cycle(0, 0);

    // Random traffic, stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 45 && q0.size() < 8) q0.push_back(rand_word(0));
      if ($urandom_range(0, 99) < 45 && q1.size() < 8) q1.push_back(rand_word(1));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20);
    end
    repeat (20) cycle(0, 0);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
